pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU; drives the shared 6-bit stall bus consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Merges stall requests from IF, ID, EX and MEM into one stall vector.
- Owns a cycle counter for multi-cycle EX operations (div, madd/msub).
- Issues a pipeline flush with a new PC on exceptions and counts stalled cycles for performance monitoring.

Parameters:
- CNT_W, 6, width of the multi-cycle EX countdown (max 63 cycles).
- FLUSH_CYCLES, 1, cycles after a flush during which stall requests are ignored; legal range 1..3.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stallreq_if  in  1  instruction fetch not ready.
- stallreq_id  in  1  load-use hazard detected in ID.
- stallreq_ex  in  1  single-cycle EX stall request.
- ex_multi_start  in  1  EX issues a multi-cycle op this cycle.
- ex_multi_cycles  in  CNT_W  total cycles for that op, N.
- stallreq_mem  in  1  data bus not ready.
- excp_valid  in  1  exception committed in MEM.
- excp_new_pc  in  32  handler or EPC target.
- stall  out  6  stall bus; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  PC to load when flush = 1.
- ex_multi_done  out  1  one-cycle pulse: multi-cycle result valid.
- ex_multi_abort  out  1  one-cycle pulse: multi-cycle op killed by a flush.
- busy  out  1  state is EX_BUSY.
- stall_cycles  out  PERF_W  count of cycles with stall[0] = 1.

Behaviour:
- Stall encodings. A request from stage k stops stages 0..k:
  - IF: 000011
  - ID: 000111
  - EX: 001111
  - MEM: 011111
  - Stall is combinational from requests and registered state. Priority is MEM > EX > ID > IF; the highest-priority active request wins, and lower requests add nothing.
- EX stall source is asserted when any of these holds:
  - stallreq_ex = 1;
  - (state = RUN and ex_multi_start = 1 and N != 0);
  - (state = EX_BUSY and cnt != 0).
- Flush:
  - flush = excp_valid, combinational.
  - When excp_valid = 1: new_pc = excp_new_pc and stall = 000000, overriding all requests. Otherwise new_pc = 0.
- FSM states: RUN, EX_BUSY, FLUSH.
  - RUN:
    - excp_valid → FLUSH.
    - ex_multi_start with N >= 2 → EX_BUSY, cnt <= N-1.
    - ex_multi_start with N = 1 → one stall cycle only, ex_multi_done pulses next cycle, stay in RUN.
    - N = 0 → ignored.
  - EX_BUSY:
    - excp_valid → FLUSH, cnt <= 0, ex_multi_abort = 1 that cycle, no done pulse.
    - Else if stallreq_mem = 1 → cnt frozen.
    - Else if cnt = 1 → cnt <= 0, next cycle ex_multi_done = 1, state → RUN.
    - Else cnt <= cnt-1.
    - ex_multi_start is ignored in EX_BUSY.
    - Net effect: exactly N stall cycles, counting the start cycle; done is asserted in cycle N+1 of the sequence (stall = 0 that cycle unless another request is active).
  - FLUSH:
    - Lasts FLUSH_CYCLES cycles, tracked by a separate down-counter.
    - stall = 000000 for stallreq_id, stallreq_ex and ex_multi_start, which are ignored; stallreq_if and stallreq_mem are still honoured.
    - A new excp_valid restarts the FLUSH count.
    - Exit → RUN.
- stall_cycles:
  - Increments when stall[0] = 1.
  - Saturates at all-ones; no wrap.
- Reset, synchronous and taking priority over all inputs, sets:
  - state RUN, cnt 0, flush counter 0, stall_cycles 0, done/abort 0.
  - Combinational outputs then follow inputs; stall = 000000 while rst = 1.
- Simultaneous events:
  - excp_valid together with ex_multi_start: the start is discarded and no busy state is entered.
  - stallreq_mem during the done cycle: done still pulses exactly once.

Decomposition:
- Add to defines.v:
  - StallBus 5:0, Stop/NotStop;
  - stall encodings STALL_IF/ID/EX/MEM/NONE;
  - FSM state codes CTRL_RUN/CTRL_EXBUSY/CTRL_FLUSH.
- One natural sub-module: stall_encoder, a combinational priority encoder from the 4 request bits to the 6-bit stall vector. The FSM, counters and perf counter stay in pipe_ctrl.

Test Plan:
- stallreq_id = 1 for 1 cycle in RUN → stall = 000111 that cycle, 000000 next; stall_cycles = 1.
- ex_multi_start, N = 33 → stall = 001111 for exactly 33 consecutive cycles; ex_multi_done pulses once on cycle 34; busy = 1 for cycles 2..33.
- N = 5 with stallreq_mem held for 3 cycles mid-op → stall = 011111 during those 3 cycles; done delayed by 3 cycles (arrives cycle 9).
- excp_valid at cycle 10 of a 33-cycle op with excp_new_pc = 0x00000020 → flush = 1, new_pc = 0x20, stall = 0, abort pulse, no done ever; stallreq_id ignored the next cycle.
- stallreq_if, stallreq_id and stallreq_mem all asserted → stall = 011111; drop mem → 000111; drop id → 000011.
- rst asserted in EX_BUSY → next cycle busy = 0, stall_cycles = 0, no done/abort pulse.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared stall-bus definitions and sequencer state codes for the pipeline controller.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;

  // A request from stage k stops stages 0..k
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_EXBUSY,
    CTRL_FLUSH
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder from per-stage stall requests to the 6-bit stall bus (MEM > EX > ID > IF).
module stall_encoder
  import pipe_ctrl_pkg::*;
(
  input  logic               req_if,
  input  logic               req_id,
  input  logic               req_ex,
  input  logic               req_mem,
  output logic [STALL_W-1:0] stall
);

  always_comb begin
    stall = {STALL_W{NOT_STOP}};
    if (req_mem)     stall = STALL_MEM;
    else if (req_ex) stall = STALL_EX;
    else if (req_id) stall = STALL_ID;
    else if (req_if) stall = STALL_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, times multi-cycle EX ops,
// issues exception flushes and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              ex_multi_start,
  input  logic [CNT_W-1:0]  ex_multi_cycles,
  input  logic              stallreq_mem,
  input  logic              excp_valid,
  input  logic [31:0]       excp_new_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              ex_multi_done,
  output logic              ex_multi_abort,
  output logic              busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [1:0] FLUSH_LEN = 2'(FLUSH_CYCLES);

  ctrl_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       fcnt, fcnt_next;
  logic             done_q, done_next;
  logic             multi_req;
  logic             req_id, req_ex;
  logic [5:0]       enc_stall;

  assign multi_req = ex_multi_start && (ex_multi_cycles != '0);

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    fcnt_next      = fcnt;
    done_next      = 1'b0;
    ex_multi_abort = 1'b0;
    unique case (state)
      CTRL_RUN: begin
        if (excp_valid) begin
          state_next = CTRL_FLUSH;
          fcnt_next  = FLUSH_LEN;
        end else if (multi_req) begin
          // A one-cycle op never enters EX_BUSY; its single stall comes from multi_req
          if (ex_multi_cycles == CNT_W'(1)) begin
            done_next = 1'b1;
          end else begin
            state_next = CTRL_EXBUSY;
            cnt_next   = ex_multi_cycles - CNT_W'(1);
          end
        end
      end
      CTRL_EXBUSY: begin
        if (excp_valid) begin
          state_next     = CTRL_FLUSH;
          fcnt_next      = FLUSH_LEN;
          cnt_next       = '0;
          ex_multi_abort = 1'b1;
        end else if (!stallreq_mem) begin
          if (cnt == CNT_W'(1)) begin
            state_next = CTRL_RUN;
            cnt_next   = '0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      CTRL_FLUSH: begin
        if (excp_valid) begin
          fcnt_next = FLUSH_LEN;
        end else if (fcnt <= 2'd1) begin
          state_next = CTRL_RUN;
          fcnt_next  = '0;
        end else begin
          fcnt_next = fcnt - 2'd1;
        end
      end
      default: state_next = CTRL_RUN;
    endcase
    if (rst) ex_multi_abort = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CTRL_RUN;
      cnt    <= '0;
      fcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      fcnt   <= fcnt_next;
      done_q <= done_next;
    end
  end

  // ID and EX requests are ignored while the pipeline refills after a flush
  always_comb begin
    req_id = stallreq_id && (state != CTRL_FLUSH);
    req_ex = (state != CTRL_FLUSH) &&
             (stallreq_ex ||
              ((state == CTRL_RUN) && multi_req) ||
              ((state == CTRL_EXBUSY) && (cnt != '0)));
  end

  stall_encoder u_stall_encoder (
    .req_if  (stallreq_if),
    .req_id  (req_id),
    .req_ex  (req_ex),
    .req_mem (stallreq_mem),
    .stall   (enc_stall)
  );

  always_comb begin
    stall         = (rst || excp_valid) ? STALL_NONE : enc_stall;
    flush         = excp_valid;
    new_pc        = excp_valid ? excp_new_pc : '0;
    ex_multi_done = done_q;
    busy          = (state == CTRL_EXBUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((stall[0] == STOP) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; a second instance with a 3-bit perf counter covers saturation.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        ex_multi_start;
  logic [5:0]  ex_multi_cycles;
  logic        excp_valid;
  logic [31:0] excp_new_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_multi_done, ex_multi_abort, busy;
  logic [31:0] stall_cycles;

  logic [5:0]  sat_stall;
  logic        sat_flush;
  logic [31:0] sat_new_pc;
  logic        sat_done, sat_abort, sat_busy;
  logic [2:0]  sat_stall_cycles;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        seen;

  pipe_ctrl #(.CNT_W(6), .FLUSH_CYCLES(1), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_multi_start(ex_multi_start), .ex_multi_cycles(ex_multi_cycles),
    .stallreq_mem(stallreq_mem), .excp_valid(excp_valid), .excp_new_pc(excp_new_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .ex_multi_done(ex_multi_done), .ex_multi_abort(ex_multi_abort),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  pipe_ctrl #(.CNT_W(6), .FLUSH_CYCLES(1), .PERF_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_multi_start(ex_multi_start), .ex_multi_cycles(ex_multi_cycles),
    .stallreq_mem(stallreq_mem), .excp_valid(excp_valid), .excp_new_pc(excp_new_pc),
    .stall(sat_stall), .flush(sat_flush), .new_pc(sat_new_pc),
    .ex_multi_done(sat_done), .ex_multi_abort(sat_abort),
    .busy(sat_busy), .stall_cycles(sat_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are driven here
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    ex_multi_start = 0; ex_multi_cycles = '0; excp_valid = 0; excp_new_pc = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset state
    next_cycle(); next_cycle();
    stallreq_id = 1; #1;
    check("rst_stall", 32'(stall), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(ex_multi_done), 32'h0);
    check("rst_perf", stall_cycles, 32'h0);
    next_cycle();
    rst = 1'b0; stallreq_id = 0; #1;
    check("post_rst_stall", 32'(stall), 32'h00);
    check("post_rst_newpc", new_pc, 32'h0);
    check("post_rst_flush", 32'(flush), 32'h0);

    // Single-cycle ID request
    next_cycle();
    stallreq_id = 1; #1;
    check("id_stall", 32'(stall), 32'h07);
    next_cycle();
    stallreq_id = 0; #1;
    check("id_release", 32'(stall), 32'h00);
    check("id_perf", stall_cycles, 32'd1);

    // 33-cycle multi-cycle op
    next_cycle();
    ex_multi_start = 1; ex_multi_cycles = 6'd33; #1;
    check("n33_c1_stall", 32'(stall), 32'h0f);
    check("n33_c1_busy", 32'(busy), 32'h0);
    for (int c = 2; c <= 33; c++) begin
      next_cycle();
      ex_multi_start = (c == 2); ex_multi_cycles = 6'd7; #1;
      check($sformatf("n33_c%0d_stall", c), 32'(stall), 32'h0f);
      check($sformatf("n33_c%0d_busy", c), 32'(busy), 32'h1);
      check($sformatf("n33_c%0d_done", c), 32'(ex_multi_done), 32'h0);
    end
    next_cycle();
    clear_inputs(); #1;
    check("n33_c34_done", 32'(ex_multi_done), 32'h1);
    check("n33_c34_stall", 32'(stall), 32'h00);
    check("n33_c34_busy", 32'(busy), 32'h0);
    next_cycle(); #1;
    check("n33_c35_done", 32'(ex_multi_done), 32'h0);
    check("n33_perf", stall_cycles, 32'd34);

    // N=5 with MEM stall held in cycles 3..5: done moves from cycle 6 to 9
    ex_multi_start = 1; ex_multi_cycles = 6'd5; #1;
    check("n5_c1_stall", 32'(stall), 32'h0f);
    for (int c = 2; c <= 9; c++) begin
      next_cycle();
      clear_inputs();
      stallreq_mem = (c >= 3 && c <= 5); #1;
      check($sformatf("n5_c%0d_stall", c), 32'(stall),
            (c >= 3 && c <= 5) ? 32'h1f : (c <= 8 ? 32'h0f : 32'h00));
      check($sformatf("n5_c%0d_done", c), 32'(ex_multi_done), (c == 9) ? 32'h1 : 32'h0);
    end
    check("n5_perf", stall_cycles, 32'd42);

    // Exception in cycle 10 of a 33-cycle op
    next_cycle();
    ex_multi_start = 1; ex_multi_cycles = 6'd33; #1;
    for (int c = 2; c <= 9; c++) begin
      next_cycle();
      clear_inputs(); #1;
    end
    check("ex_c9_busy", 32'(busy), 32'h1);
    next_cycle();
    excp_valid = 1; excp_new_pc = 32'h0000_0020; #1;
    check("excp_flush", 32'(flush), 32'h1);
    check("excp_newpc", new_pc, 32'h0000_0020);
    check("excp_stall", 32'(stall), 32'h00);
    check("excp_abort", 32'(ex_multi_abort), 32'h1);
    next_cycle();
    clear_inputs(); stallreq_id = 1; #1;
    check("flush_id_ignored", 32'(stall), 32'h00);
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_abort_gone", 32'(ex_multi_abort), 32'h0);
    check("flush_deassert", 32'(flush), 32'h0);
    next_cycle(); #1;
    check("after_flush_id", 32'(stall), 32'h07);
    next_cycle();
    clear_inputs();
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      seen = seen | ex_multi_done;
      next_cycle();
    end
    check("abort_no_done", 32'(seen), 32'h0);
    check("abort_perf", stall_cycles, 32'd52);

    // Priority: IF+ID+MEM, then drop MEM, then drop ID
    stallreq_if = 1; stallreq_id = 1; stallreq_mem = 1; #1;
    check("prio_mem", 32'(stall), 32'h1f);
    next_cycle();
    stallreq_mem = 0; #1;
    check("prio_id", 32'(stall), 32'h07);
    next_cycle();
    stallreq_id = 0; #1;
    check("prio_if", 32'(stall), 32'h03);
    next_cycle();
    clear_inputs(); #1;
    check("prio_perf", stall_cycles, 32'd55);

    // N=1: one stall cycle, done next cycle, never busy
    ex_multi_start = 1; ex_multi_cycles = 6'd1; #1;
    check("n1_stall", 32'(stall), 32'h0f);
    next_cycle();
    clear_inputs(); #1;
    check("n1_done", 32'(ex_multi_done), 32'h1);
    check("n1_busy", 32'(busy), 32'h0);
    check("n1_stall_after", 32'(stall), 32'h00);

    // Exception together with a start: start discarded; IF still honoured in FLUSH
    next_cycle();
    ex_multi_start = 1; ex_multi_cycles = 6'd5; excp_valid = 1; excp_new_pc = 32'h0000_0100; #1;
    check("xs_stall", 32'(stall), 32'h00);
    check("xs_newpc", new_pc, 32'h0000_0100);
    check("xs_abort", 32'(ex_multi_abort), 32'h0);
    next_cycle();
    clear_inputs(); stallreq_if = 1; stallreq_id = 1; #1;
    check("xs_flush_if", 32'(stall), 32'h03);
    check("xs_busy", 32'(busy), 32'h0);
    next_cycle();
    clear_inputs(); #1;
    check("xs_run_stall", 32'(stall), 32'h00);
    check("xs_run_busy", 32'(busy), 32'h0);
    check("xs_no_done", 32'(ex_multi_done), 32'h0);
    check("xs_perf", stall_cycles, 32'd57);
    check("sat_perf", 32'(sat_stall_cycles), 32'd7);

    // Reset while in EX_BUSY
    next_cycle();
    ex_multi_start = 1; ex_multi_cycles = 6'd10; #1;
    next_cycle();
    clear_inputs(); #1;
    next_cycle(); #1;
    check("rb_busy_before", 32'(busy), 32'h1);
    next_cycle();
    rst = 1'b1; #1;
    check("rb_stall_in_rst", 32'(stall), 32'h00);
    check("rb_abort_in_rst", 32'(ex_multi_abort), 32'h0);
    next_cycle();
    rst = 1'b0; #1;
    check("rb_busy", 32'(busy), 32'h0);
    check("rb_perf", stall_cycles, 32'h0);
    check("rb_sat_perf", 32'(sat_stall_cycles), 32'h0);
    check("rb_done", 32'(ex_multi_done), 32'h0);
    check("rb_abort", 32'(ex_multi_abort), 32'h0);
    check("rb_stall", 32'(stall), 32'h00);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      next_cycle(); #1;
      seen = seen | ex_multi_done | ex_multi_abort;
    end
    check("rb_no_pulse", 32'(seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
